// File: rtl/axi_lite_decoder_1to2.sv
// axi_lite_decoder_1to2: routes one AXI4-Lite transaction at a time from one master to one of two slaves, with decode-error and timeout handling.
module axi_lite_decoder_1to2 #(
    parameter logic [31:0] S0_BASE   = 32'h0000_0000,
    parameter logic [31:0] S0_MASK   = 32'hFFFF_0000,
    parameter logic [31:0] S1_BASE   = 32'h0200_0000,
    parameter logic [31:0] S1_MASK   = 32'hFFFF_FFF0,
    parameter logic [31:0] ERR_RDATA = 32'hDEAD_BEEF,
    parameter int          TIMEOUT   = 255
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        mem_axi_awvalid,
    output logic        mem_axi_awready,
    input  logic [31:0] mem_axi_awaddr,
    input  logic [2:0]  mem_axi_awprot,
    input  logic        mem_axi_wvalid,
    output logic        mem_axi_wready,
    input  logic [31:0] mem_axi_wdata,
    input  logic [3:0]  mem_axi_wstrb,
    output logic        mem_axi_bvalid,
    input  logic        mem_axi_bready,
    input  logic        mem_axi_arvalid,
    output logic        mem_axi_arready,
    input  logic [31:0] mem_axi_araddr,
    input  logic [2:0]  mem_axi_arprot,
    output logic        mem_axi_rvalid,
    input  logic        mem_axi_rready,
    output logic [31:0] mem_axi_rdata,
    output logic        s0_axi_awvalid,
    input  logic        s0_axi_awready,
    output logic [31:0] s0_axi_awaddr,
    output logic [2:0]  s0_axi_awprot,
    output logic        s0_axi_wvalid,
    input  logic        s0_axi_wready,
    output logic [31:0] s0_axi_wdata,
    output logic [3:0]  s0_axi_wstrb,
    input  logic        s0_axi_bvalid,
    output logic        s0_axi_bready,
    output logic        s0_axi_arvalid,
    input  logic        s0_axi_arready,
    output logic [31:0] s0_axi_araddr,
    output logic [2:0]  s0_axi_arprot,
    input  logic        s0_axi_rvalid,
    output logic        s0_axi_rready,
    input  logic [31:0] s0_axi_rdata,
    output logic        s1_axi_awvalid,
    input  logic        s1_axi_awready,
    output logic [31:0] s1_axi_awaddr,
    output logic [2:0]  s1_axi_awprot,
    output logic        s1_axi_wvalid,
    input  logic        s1_axi_wready,
    output logic [31:0] s1_axi_wdata,
    output logic [3:0]  s1_axi_wstrb,
    input  logic        s1_axi_bvalid,
    output logic        s1_axi_bready,
    output logic        s1_axi_arvalid,
    input  logic        s1_axi_arready,
    output logic [31:0] s1_axi_araddr,
    output logic [2:0]  s1_axi_arprot,
    input  logic        s1_axi_rvalid,
    output logic        s1_axi_rready,
    input  logic [31:0] s1_axi_rdata,
    output logic        decerr_pulse,
    output logic        timeout_pulse
);
    localparam int CW = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(TIMEOUT);

    typedef enum logic [2:0] {IDLE, W_DATA, W_FWD, W_RESP, B_OUT, R_FWD, R_RESP, R_OUT} state_t;
    typedef enum logic [1:0] {SEL_S0, SEL_S1, SEL_ERR} sel_t;

    state_t state;
    sel_t sel;
    logic [31:0] addr, wdata, rdata;
    logic [2:0] prot;
    logic [3:0] wstrb;
    logic aw_pend, w_pend, expired, on0, on1;
    logic sel_awready, sel_wready, sel_bvalid, sel_arready, sel_rvalid;
    logic [31:0] sel_rdata;
    logic [CW-1:0] cnt;

    function automatic sel_t decode(input logic [31:0] a);
        return ((a & S0_MASK) == S0_BASE) ? SEL_S0 : ((a & S1_MASK) == S1_BASE) ? SEL_S1 : SEL_ERR;
    endfunction

    // At the timeout cycle every downstream valid/ready is already withdrawn, so no handshake can race the abort.
    assign expired = (cnt == CNT_MAX) && (state inside {W_FWD, W_RESP, R_FWD, R_RESP});
    assign on0 = sel == SEL_S0 && cnt != CNT_MAX;
    assign on1 = sel == SEL_S1 && cnt != CNT_MAX;

    assign mem_axi_awready = state == IDLE;
    assign mem_axi_arready = state == IDLE && !mem_axi_awvalid;
    assign mem_axi_wready  = state == W_DATA;
    assign mem_axi_bvalid  = state == B_OUT;
    assign mem_axi_rvalid  = state == R_OUT;
    assign mem_axi_rdata   = rdata;

    assign s0_axi_awvalid = on0 && state == W_FWD && aw_pend;
    assign s0_axi_wvalid  = on0 && state == W_FWD && w_pend;
    assign s0_axi_bready  = on0 && state == W_RESP;
    assign s0_axi_arvalid = on0 && state == R_FWD;
    assign s0_axi_rready  = on0 && state == R_RESP;
    assign s1_axi_awvalid = on1 && state == W_FWD && aw_pend;
    assign s1_axi_wvalid  = on1 && state == W_FWD && w_pend;
    assign s1_axi_bready  = on1 && state == W_RESP;
    assign s1_axi_arvalid = on1 && state == R_FWD;
    assign s1_axi_rready  = on1 && state == R_RESP;

    assign s0_axi_awaddr = addr;
    assign s1_axi_awaddr = addr;
    assign s0_axi_araddr = addr;
    assign s1_axi_araddr = addr;
    assign s0_axi_awprot = prot;
    assign s1_axi_awprot = prot;
    assign s0_axi_arprot = prot;
    assign s1_axi_arprot = prot;
    assign s0_axi_wdata  = wdata;
    assign s1_axi_wdata  = wdata;
    assign s0_axi_wstrb  = wstrb;
    assign s1_axi_wstrb  = wstrb;

    assign sel_awready = (sel == SEL_S1) ? s1_axi_awready : s0_axi_awready;
    assign sel_wready  = (sel == SEL_S1) ? s1_axi_wready  : s0_axi_wready;
    assign sel_bvalid  = (sel == SEL_S1) ? s1_axi_bvalid  : s0_axi_bvalid;
    assign sel_arready = (sel == SEL_S1) ? s1_axi_arready : s0_axi_arready;
    assign sel_rvalid  = (sel == SEL_S1) ? s1_axi_rvalid  : s0_axi_rvalid;
    assign sel_rdata   = (sel == SEL_S1) ? s1_axi_rdata   : s0_axi_rdata;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state <= IDLE;
            sel <= SEL_ERR;
            addr <= '0;
            prot <= '0;
            wdata <= '0;
            wstrb <= '0;
            rdata <= '0;
            aw_pend <= 1'b0;
            w_pend <= 1'b0;
            cnt <= '0;
            decerr_pulse <= 1'b0;
            timeout_pulse <= 1'b0;
        end else begin
            decerr_pulse <= 1'b0;
            timeout_pulse <= 1'b0;
            if (state inside {W_FWD, W_RESP, R_FWD, R_RESP}) cnt <= cnt + 1'b1;
            if (expired) begin
                timeout_pulse <= 1'b1;
                aw_pend <= 1'b0;
                w_pend <= 1'b0;
                state <= (state == W_FWD || state == W_RESP) ? B_OUT : R_OUT;
                if (state == R_FWD || state == R_RESP) rdata <= ERR_RDATA;
            end else begin
                case (state)
                    IDLE:
                        if (mem_axi_awvalid) begin
                            addr <= mem_axi_awaddr;
                            prot <= mem_axi_awprot;
                            sel <= decode(mem_axi_awaddr);
                            state <= W_DATA;
                        end else if (mem_axi_arvalid) begin
                            addr <= mem_axi_araddr;
                            prot <= mem_axi_arprot;
                            sel <= decode(mem_axi_araddr);
                            cnt <= '0;
                            if (decode(mem_axi_araddr) == SEL_ERR) begin
                                rdata <= ERR_RDATA;
                                decerr_pulse <= 1'b1;
                                state <= R_OUT;
                            end else begin
                                state <= R_FWD;
                            end
                        end
                    W_DATA:
                        if (mem_axi_wvalid) begin
                            wdata <= mem_axi_wdata;
                            wstrb <= mem_axi_wstrb;
                            cnt <= '0;
                            aw_pend <= sel != SEL_ERR;
                            w_pend <= sel != SEL_ERR;
                            decerr_pulse <= sel == SEL_ERR;
                            state <= (sel == SEL_ERR) ? B_OUT : W_FWD;
                        end
                    W_FWD: begin
                        aw_pend <= aw_pend && !sel_awready;
                        w_pend <= w_pend && !sel_wready;
                        if ((!aw_pend || sel_awready) && (!w_pend || sel_wready)) state <= W_RESP;
                    end
                    W_RESP: if (sel_bvalid) state <= B_OUT;
                    B_OUT: if (mem_axi_bready) state <= IDLE;
                    R_FWD: if (sel_arready) state <= R_RESP;
                    R_RESP:
                        if (sel_rvalid) begin
                            rdata <= sel_rdata;
                            state <= R_OUT;
                        end
                    R_OUT: if (mem_axi_rready) state <= IDLE;
                    default: state <= IDLE;
                endcase
            end
        end
    end
endmodule
